// File: rtl/mul8u_dot_acc_if.sv
// Handshake bundle between the multiplier product stream, the dot-product
// accumulator and the result consumer.
interface mul8u_dot_acc_if #(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 24,
    parameter int CNT_W  = 9
);
    logic [PROD_W-1:0] in_prod;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic [ACC_W-1:0]  out_acc;
    logic [CNT_W-1:0]  out_len;
    logic              out_ovf;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output in_prod, in_valid, in_last, out_ready,
        input  in_ready, out_acc, out_len, out_ovf, out_valid
    );

    modport slave (
        input  in_prod, in_valid, in_last, out_ready,
        output in_ready, out_acc, out_len, out_ovf, out_valid
    );
endinterface

// File: rtl/mul8u_dot_acc.sv
// Dot-product accumulator for 8x8 unsigned multiplier products: sums each vector
// and emits one result per vector. Define MUL8U_DOT_ACC_SAT_EN to saturate instead of wrap.
module mul8u_dot_acc #(
    parameter int PROD_W  = 16,
    parameter int ACC_W   = 24,
    parameter int MAX_LEN = 256,
    parameter int CNT_W   = 9
) (
    input  logic             clk,
    input  logic             rst,
    mul8u_dot_acc_if.slave   bus
);
    typedef enum logic [0:0] {
        ST_ACC = 1'b0,
        ST_OUT = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [ACC_W-1:0]   out_acc_q, out_acc_d;
    logic [CNT_W-1:0]   out_len_q, out_len_d;
    logic               out_ovf_q, out_ovf_d;
    logic               out_valid_q, out_valid_d;

    logic               accept_s;
    logic               close_s;
    logic [ACC_W-1:0]   base_s;
    logic [ACC_W:0]     sum_s;
    logic [ACC_W-1:0]   acc_new_s;
    logic               ovf_new_s;
    logic [CNT_W-1:0]   cnt_inc_s;

    // Carry-out handling: clamp to all-ones in saturating builds, otherwise wrap.
    function automatic logic [ACC_W-1:0] fold_sum(input logic [ACC_W:0] s);
`ifdef MUL8U_DOT_ACC_SAT_EN
        if (s[ACC_W]) begin
            return {ACC_W{1'b1}};
        end else begin
            return s[ACC_W-1:0];
        end
`else
        return s[ACC_W-1:0];
`endif
    endfunction

    // Next-state and result computation for the ACC/OUT controller.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_acc_d   = out_acc_q;
        out_len_d   = out_len_q;
        out_ovf_d   = out_ovf_q;
        out_valid_d = out_valid_q;

        accept_s  = bus.in_valid & (state_q == ST_ACC);
        // First beat of a vector ignores whatever acc/ovf still hold.
        base_s    = (cnt_q == {CNT_W{1'b0}}) ? {ACC_W{1'b0}} : acc_q;
        sum_s     = {1'b0, base_s} + {{(ACC_W + 1 - PROD_W){1'b0}}, bus.in_prod};
        acc_new_s = fold_sum(sum_s);
        ovf_new_s = ((cnt_q == {CNT_W{1'b0}}) ? 1'b0 : ovf_q) | sum_s[ACC_W];
        cnt_inc_s = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        close_s   = bus.in_last | (cnt_inc_s == CNT_W'(MAX_LEN));

        case (state_q)
            ST_ACC: begin
                if (accept_s) begin
                    acc_d = acc_new_s;
                    ovf_d = ovf_new_s;
                    if (close_s) begin
                        out_acc_d   = acc_new_s;
                        out_len_d   = cnt_inc_s;
                        out_ovf_d   = ovf_new_s;
                        out_valid_d = 1'b1;
                        state_d     = ST_OUT;
                        cnt_d       = {CNT_W{1'b0}};
                    end else begin
                        cnt_d = cnt_inc_s;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_OUT: begin
                if (out_valid_q & bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_ACC;
                    acc_d       = {ACC_W{1'b0}};
                    ovf_d       = 1'b0;
                end else begin
                    out_valid_d = out_valid_q;
                end
            end
            default: begin
                state_d = ST_ACC;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ACC;
            acc_q       <= {ACC_W{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            ovf_q       <= 1'b0;
            out_acc_q   <= {ACC_W{1'b0}};
            out_len_q   <= {CNT_W{1'b0}};
            out_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_acc_q   <= out_acc_d;
            out_len_q   <= out_len_d;
            out_ovf_q   <= out_ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_ACC);
    assign bus.out_acc   = out_acc_q;
    assign bus.out_len   = out_len_q;
    assign bus.out_ovf   = out_ovf_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_mul8u_dot_acc.sv
// Scoreboard bench for mul8u_dot_acc: a 24-bit default instance plus a 16-bit
// accumulator instance for the overflow / saturation cases.
module tb_mul8u_dot_acc;
    localparam int PROD_W  = 16;
    localparam int ACC_W   = 24;
    localparam int ACC_W1  = 16;
    localparam int MAX_LEN = 256;
    localparam int CNT_W   = 9;
`ifdef MUL8U_DOT_ACC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mul8u_dot_acc_if #(.PROD_W(PROD_W), .ACC_W(ACC_W),  .CNT_W(CNT_W)) bus0 ();
    mul8u_dot_acc_if #(.PROD_W(PROD_W), .ACC_W(ACC_W1), .CNT_W(CNT_W)) bus1 ();

    mul8u_dot_acc #(.PROD_W(PROD_W), .ACC_W(ACC_W), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W))
        dut0 (.clk(clk), .rst(rst), .bus(bus0));
    mul8u_dot_acc #(.PROD_W(PROD_W), .ACC_W(ACC_W1), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));

    typedef struct {
        longint acc;
        int     len;
        bit     ovf;
    } res_t;

    res_t   q0[$];
    res_t   q1[$];
    res_t   mon_r0, mon_r1;
    int     tests  = 0;
    int     errors = 0;

    longint m_acc[2];
    int     m_len[2];
    bit     m_ovf[2];

    task automatic check(input string tag, input longint obs, input longint exp);
        tests++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_acc[d] = 0;
            m_len[d] = 0;
            m_ovf[d] = 1'b0;
        end
    endtask

    // Reference behaviour for one accepted beat; pushes a result when the vector closes.
    task automatic model_beat(input int d, input int w, input longint p, input bit last);
        longint s;
        longint lim;
        res_t   r;
        lim = longint'(1) << w;
        s = m_acc[d] + p;
        m_len[d]++;
        if (s >= lim) begin
            m_ovf[d] = 1'b1;
            s = SAT ? (lim - 1) : (s - lim);
        end
        m_acc[d] = s;
        if (last || m_len[d] == MAX_LEN) begin
            r.acc = m_acc[d];
            r.len = m_len[d];
            r.ovf = m_ovf[d];
            if (d == 0) q0.push_back(r);
            else        q1.push_back(r);
            m_acc[d] = 0;
            m_len[d] = 0;
            m_ovf[d] = 1'b0;
        end
    endtask

    task automatic send0(input longint p, input bit last);
        logic [63:0] pv;
        bit ok;
        pv = 64'(p);
        bus0.in_prod  = pv[15:0];
        bus0.in_valid = 1'b1;
        bus0.in_last  = last;
        ok = 1'b0;
        for (int t = 0; t < 1000; t++) begin
            @(negedge clk);
            if (bus0.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("in_ready_timeout0", 0, 1);
        else     model_beat(0, ACC_W, p, last);
        @(posedge clk); #1;
        bus0.in_valid = 1'b0;
        bus0.in_last  = 1'b0;
    endtask

    task automatic send1(input longint p, input bit last);
        logic [63:0] pv;
        bit ok;
        pv = 64'(p);
        bus1.in_prod  = pv[15:0];
        bus1.in_valid = 1'b1;
        bus1.in_last  = last;
        ok = 1'b0;
        for (int t = 0; t < 1000; t++) begin
            @(negedge clk);
            if (bus1.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("in_ready_timeout1", 0, 1);
        else     model_beat(1, ACC_W1, p, last);
        @(posedge clk); #1;
        bus1.in_valid = 1'b0;
        bus1.in_last  = 1'b0;
    endtask

    // Result monitors: a handshake seen at the falling edge completes on the next rising edge.
    always @(negedge clk) begin
        if (!rst && bus0.out_valid && bus0.out_ready) begin
            if (q0.size() == 0) begin
                check("sb0_unexpected", 1, 0);
            end else begin
                mon_r0 = q0.pop_front();
                check("acc0", bus0.out_acc, mon_r0.acc);
                check("len0", bus0.out_len, mon_r0.len);
                check("ovf0", bus0.out_ovf, mon_r0.ovf);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && bus1.out_valid && bus1.out_ready) begin
            if (q1.size() == 0) begin
                check("sb1_unexpected", 1, 0);
            end else begin
                mon_r1 = q1.pop_front();
                check("acc1", bus1.out_acc, mon_r1.acc);
                check("len1", bus1.out_len, mon_r1.len);
                check("ovf1", bus1.out_ovf, mon_r1.ovf);
            end
        end
    end

    initial begin
        bus0.in_prod = '0; bus0.in_valid = 1'b0; bus0.in_last = 1'b0; bus0.out_ready = 1'b0;
        bus1.in_prod = '0; bus1.in_valid = 1'b0; bus1.in_last = 1'b0; bus1.out_ready = 1'b1;
        model_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", bus0.out_valid, 0);
        check("rst_out_acc",   bus0.out_acc,   0);
        check("rst_out_len",   bus0.out_len,   0);
        check("rst_out_ovf",   bus0.out_ovf,   0);
        check("rst_in_ready",  bus0.in_ready,  1);
        @(posedge clk); #1;

        // in_last without in_valid must not close anything
        bus0.in_last = 1'b1;
        repeat (2) @(posedge clk);
        #1 bus0.in_last = 1'b0;
        @(negedge clk);
        check("idle_out_valid", bus0.out_valid, 0);
        check("idle_in_ready",  bus0.in_ready,  1);
        @(posedge clk); #1;

        bus0.out_ready = 1'b1;
        send0(100, 1'b0);
        send0(200, 1'b0);
        send0(300, 1'b1);
        @(negedge clk);
        check("bubble_in_ready", bus0.in_ready,  0);
        check("bubble_valid",    bus0.out_valid, 1);
        @(negedge clk);
        check("after_in_ready",  bus0.in_ready,  1);
        @(posedge clk); #1;

        // Result back-pressured for five cycles
        bus0.out_ready = 1'b0;
        send0(65025, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid",    bus0.out_valid, 1);
            check("hold_acc",      bus0.out_acc,   65025);
            check("hold_len",      bus0.out_len,   1);
            check("hold_in_ready", bus0.in_ready,  0);
        end
        @(posedge clk); #1;
        bus0.out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("released_valid", bus0.out_valid, 0);
        @(posedge clk); #1;

        // Forced close at MAX_LEN, then a fresh vector from zero
        for (int i = 0; i < MAX_LEN; i++) send0(65025, 1'b0);
        send0(5, 1'b1);

        // 16-bit accumulator: wrap or saturate, and stay clamped once saturated
        send1(60000, 1'b0);
        send1(10000, 1'b1);
        send1(60000, 1'b0);
        send1(10000, 1'b0);
        send1(100,   1'b1);

        // Reset in the middle of a vector
        send0(1000, 1'b0);
        send0(2000, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        check("mid_rst_out_valid", bus0.out_valid, 0);
        check("mid_rst_out_acc",   bus0.out_acc,   0);
        check("mid_rst_out_len",   bus0.out_len,   0);
        check("mid_rst_in_ready",  bus0.in_ready,  1);
        @(posedge clk); #1;
        send0(5, 1'b0);
        send0(7, 1'b1);

        for (int t = 0; t < 100; t++) begin
            if (q0.size() == 0 && q1.size() == 0) break;
            @(negedge clk);
        end
        @(negedge clk);
        check("sb0_drained", q0.size(), 0);
        check("sb1_drained", q1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule

// File: doc/mul8u_dot_acc.md
Name: mul8u_dot_acc

Overview:
- Sequential accumulation stage that sits directly downstream of the 8x8 unsigned (approximate) multiplier circuits.
- Consumes a stream of 16-bit products over a valid/ready handshake and sums each vector of products into a dot-product result.
- Emits one result per vector, also on valid/ready.
- Used to measure approximate-multiplier error accumulation in MAC-style workloads.

Parameters:
- PROD_W, 16, width of incoming product (multiplier output O).
- ACC_W, 24, accumulator and result width; must be >= PROD_W.
- MAX_LEN, 256, maximum beats per vector; the vector is force-closed on beat MAX_LEN.
- CNT_W, 9, beat counter width; must hold MAX_LEN.

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_prod  in  PROD_W  product from the multiplier.
- in_valid  in  1  product valid.
- in_last  in  1  marks final product of the current vector.
- in_ready  out  1  stage can accept a product this cycle.
- out_acc  out  ACC_W  dot-product result.
- out_len  out  CNT_W  number of products in the result vector (1..MAX_LEN).
- out_ovf  out  1  accumulator exceeded 2^ACC_W-1 at least once in this vector.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.

Behaviour:
- Reset: one clock, synchronous, active-high; only rst clears state. Register values after reset:
  - state=ACC, acc=0, cnt=0, ovf=0.
  - out_acc=0, out_len=0, out_ovf=0, out_valid=0.
  - in_ready=1 on the first cycle after rst deasserts.
- States: ACC (accepting products), OUT (holding result).
- in_ready = (state==ACC), combinational from the state register only; no dependence on in_valid.
- Accepted beat: in_valid & in_ready.
  - sum = (cnt==0 ? 0 : acc) + zero-extended in_prod, computed at ACC_W+1 bits.
  - acc <= sum[ACC_W-1:0].
  - cnt <= cnt+1.
  - ovf <= (cnt==0 ? 0 : ovf) | sum[ACC_W].
- Close condition: accepted beat with in_last=1, or cnt+1==MAX_LEN.
  - Same edge: out_acc <= new acc, out_len <= cnt+1, out_ovf <= new ovf, out_valid <= 1.
  - Same edge: state <= OUT, cnt <= 0.
  - Latency is 1 cycle: the last beat accepted at edge k gives out_valid=1 from edge k onward.
- OUT state:
  - in_ready=0.
  - out_* are held stable until out_valid & out_ready.
  - On that handshake: out_valid <= 0, state <= ACC, acc <= 0, ovf <= 0.
  - Minimum one bubble cycle per vector.
- in_valid=0 in ACC: no state change; a partial vector is retained indefinitely.
- in_last=1 together with the MAX_LEN close: treated as a single close, out_len=MAX_LEN.
- in_last on a beat that is not accepted: ignored.
- Reset mid-vector or mid-OUT: the partial sum and any pending result are discarded, and all outputs return to their reset values.
- Arithmetic is unsigned; no rounding or truncation of in_prod.

Optional Feature:
- Macro: MUL8U_DOT_ACC_SAT_EN.
- Defined: when sum[ACC_W]=1, acc is clamped to all-ones (2^ACC_W-1). Once clamped, acc stays all-ones for the rest of the vector. out_acc reports the clamped value; out_ovf still asserts.
- Undefined: acc wraps modulo 2^ACC_W; out_ovf flags the wrap.

Test Plan:
- rst high 2 cycles, then low -> out_valid=0, out_acc=0, out_len=0, in_ready=1 on the first cycle after reset.
- Products 100, 200, 300 (last on 300), out_ready=1 -> one cycle after the last beat: out_acc=600, out_len=3, out_ovf=0; in_ready=0 for exactly that cycle, then 1.
- Single beat 65025 with last, out_ready=0 for 5 cycles -> out_acc=65025 held stable with out_valid=1 for all 5 cycles; in_ready=0 throughout; accepted on the 6th cycle.
- 256 beats of 65025, no in_last -> forced close: out_len=256, out_acc=16646400, out_ovf=0. The next vector's first beat starts from 0.
- Build with ACC_W=16; beats 60000, 10000 (last):
  - Without macro: out_acc=4464, out_ovf=1.
  - With MUL8U_DOT_ACC_SAT_EN: out_acc=65535, out_ovf=1.
- Assert rst in the middle of a 3-beat vector after 2 beats, then send a fresh vector 5, 7 (last) -> out_acc=12, out_len=2.
